// File: rtl/cache_refill_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cache_refill_ctrl
// Purpose  : Refill controller between a direct-mapped data cache and main
//            memory. On a read miss it fetches the 4-word line critical word
//            first and hands each word to the cache with the counter protocol
//            (counter 1..4 = word k, counter 5 = set valid/tag).
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   1  rising-edge clock
//   rst          in   1  synchronous active-low reset
//   miss         in   1  refill request (cache IsStall), sampled only in IDLE
//   addr         in  32  CPU address, [1:0] = critical word offset
//   mem_ack      in   1  memory accepts request, mem_rdata valid same cycle
//   mem_rdata    in  32  memory read word
//   mem_req      out  1  memory read request, held until mem_ack
//   mem_addr     out 32  {line_addr, word select}
//   counter      out  3  0 idle, 1..4 word k, 5 finalize
//   memory_word  out 32  word for the cache, valid while counter is 1..4
//   busy         out  1  refill in progress
//   refill_err   out  1  one-cycle pulse on memory timeout
// Configuration
//   REFILL_TIMEOUT_EN : when defined, a per-word wait counter aborts a refill
//                       after TIMEOUT_CYCLES cycles without mem_ack (ERR
//                       state). When undefined REQ waits forever and
//                       refill_err is constant 0.
// ============================================================================
module cache_refill_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        miss,
  input  logic [31:0] addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [2:0]  counter,
  output logic [31:0] memory_word,
  output logic        busy,
  output logic        refill_err
);

`ifdef REFILL_TIMEOUT_EN
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ     = 3'd1,
    ST_DELIVER = 3'd2,
    ST_FILL    = 3'd3,
    ST_ERR     = 3'd4
  } state_t;

  localparam int unsigned WAIT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              refill_err_q, refill_err_d;
`else
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_DELIVER = 2'd2,
    ST_FILL    = 2'd3
  } state_t;
`endif

  state_t      state_q, state_d;
  logic [29:0] line_addr_q, line_addr_d;
  logic [1:0]  off_q, off_d;
  logic [2:0]  k_q, k_d;            // word index 1..4 of the current word
  logic        mem_req_q, mem_req_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [2:0]  counter_q, counter_d;
  logic [31:0] memory_word_q, memory_word_d;
  logic        busy_q, busy_d;

  // Every output is registered: the *_d values describe what the outputs
  // must show in the state being entered, not the state being left.
  always_comb begin
    state_d       = state_q;
    line_addr_d   = line_addr_q;
    off_d         = off_q;
    k_d           = k_q;
    mem_req_d     = 1'b0;
    mem_addr_d    = mem_addr_q;
    counter_d     = 3'd0;
    memory_word_d = memory_word_q;
`ifdef REFILL_TIMEOUT_EN
    wait_d        = wait_q;
    refill_err_d  = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (miss) begin
          state_d     = ST_REQ;
          line_addr_d = addr[31:2];
          off_d       = addr[1:0];
          k_d         = 3'd1;
          mem_req_d   = 1'b1;
          // First word is the critical one, so its select is the offset.
          mem_addr_d  = addr;
`ifdef REFILL_TIMEOUT_EN
          wait_d      = '0;
`endif
        end
      end

      ST_REQ: begin
        if (mem_ack) begin
          state_d       = ST_DELIVER;
          memory_word_d = mem_rdata;
          counter_d     = k_q;
`ifdef REFILL_TIMEOUT_EN
        end else if (wait_q == WAIT_LAST) begin
          // A late ack in the final wait cycle still wins over the timeout.
          state_d      = ST_ERR;
          refill_err_d = 1'b1;
`endif
        end else begin
          mem_req_d = 1'b1;
`ifdef REFILL_TIMEOUT_EN
          wait_d    = wait_q + 1'b1;
`endif
        end
      end

      ST_DELIVER: begin
        if (k_q == 3'd4) begin
          state_d   = ST_FILL;
          counter_d = 3'd5;
        end else begin
          state_d    = ST_REQ;
          k_d        = k_q + 3'd1;
          mem_req_d  = 1'b1;
          // Select for word k+1 is (off + k) mod 4; the 2-bit add wraps.
          mem_addr_d = {line_addr_q, off_q + k_q[1:0]};
`ifdef REFILL_TIMEOUT_EN
          wait_d     = '0;
`endif
        end
      end

      ST_FILL: begin
        state_d = ST_IDLE;
      end

`ifdef REFILL_TIMEOUT_EN
      ST_ERR: begin
        state_d = ST_IDLE;
      end
`endif

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      line_addr_q   <= '0;
      off_q         <= '0;
      k_q           <= '0;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= '0;
      counter_q     <= '0;
      memory_word_q <= '0;
      busy_q        <= 1'b0;
`ifdef REFILL_TIMEOUT_EN
      wait_q        <= '0;
      refill_err_q  <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      line_addr_q   <= line_addr_d;
      off_q         <= off_d;
      k_q           <= k_d;
      mem_req_q     <= mem_req_d;
      mem_addr_q    <= mem_addr_d;
      counter_q     <= counter_d;
      memory_word_q <= memory_word_d;
      busy_q        <= busy_d;
`ifdef REFILL_TIMEOUT_EN
      wait_q        <= wait_d;
      refill_err_q  <= refill_err_d;
`endif
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  assign counter     = counter_q;
  assign memory_word = memory_word_q;
  assign busy        = busy_q;
`ifdef REFILL_TIMEOUT_EN
  assign refill_err  = refill_err_q;
`else
  assign refill_err  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cache_refill_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_refill_ctrl
// Purpose  : Self-checking bench for cache_refill_ctrl. A small memory model
//            acks requests; each acked word is pushed to a scoreboard and
//            popped when the DUT presents it on counter/memory_word.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cache_refill_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        miss;
  logic [31:0] addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [2:0]  counter;
  logic [31:0] memory_word;
  logic        busy;
  logic        refill_err;

  typedef struct {
    logic [2:0]  k;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  cache_refill_ctrl #(
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .miss       (miss),
    .addr       (addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .counter    (counter),
    .memory_word(memory_word),
    .busy       (busy),
    .refill_err (refill_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mem_req"},     32'(mem_req),    32'd0);
    check({tag, "_mem_addr"},    mem_addr,        32'd0);
    check({tag, "_counter"},     32'(counter),    32'd0);
    check({tag, "_memory_word"}, memory_word,     32'd0);
    check({tag, "_busy"},        32'(busy),       32'd0);
    check({tag, "_refill_err"},  32'(refill_err), 32'd0);
  endtask

  // One refill from the IDLE cycle with miss raised. The memory answers
  // base|wsel; word stall_word waits stall_n extra cycles. abort_k != 0
  // pulls reset during the cycle where counter==abort_k.
  task automatic run_refill(input logic [31:0] a, input logic [31:0] base,
                            input int stall_word, input int stall_n, input int abort_k);
    logic [29:0] line;
    logic [1:0]  off;
    logic [1:0]  wsel;
    logic [31:0] last;
    exp_t        e;
    int          cyc;
    int          n;
    line = a[31:2];
    off  = a[1:0];
    last = 32'd0;
    cyc  = 0;
    miss = 1'b1;
    addr = a;
    check("idle_busy_c0", 32'(busy), 32'd0);
    tick(); cyc++;
    // The refill must ignore both a dropped miss and a changing address.
    miss = 1'b0;
    addr = ~a;
    for (int w = 1; w <= 4; w++) begin
      wsel = off + 2'(w - 1);
      n = (w == stall_word) ? stall_n : 0;
      for (int j = 0; j <= n; j++) begin
        check($sformatf("req_w%0d_j%0d", w, j), 32'(mem_req), 32'd1);
        check($sformatf("mem_addr_w%0d", w), mem_addr, {line, wsel});
        check($sformatf("cnt_in_req_w%0d", w), 32'(counter), 32'd0);
        if (w > 1) check($sformatf("word_hold_w%0d", w), memory_word, last);
        if (j == n) begin
          mem_ack   = 1'b1;
          mem_rdata = base | 32'(wsel);
          sb.push_back('{k: 3'(w), data: base | 32'(wsel)});
        end
        tick(); cyc++;
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
      end
      check($sformatf("req_low_w%0d", w), 32'(mem_req), 32'd0);
      check($sformatf("sb_has_w%0d", w), 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check($sformatf("counter_w%0d", w), 32'(counter), 32'(e.k));
        check($sformatf("memory_word_w%0d", w), memory_word, e.data);
        last = e.data;
      end
      if (w == abort_k) begin
        rst = 1'b0;
        tick();
        check_all_zero("abort");
        rst = 1'b1;
        return;
      end
      tick(); cyc++;
    end
    check("fill_counter", 32'(counter), 32'd5);
    check("fill_busy", 32'(busy), 32'd1);
    check("fill_refill_err", 32'(refill_err), 32'd0);
    tick(); cyc++;
    check("end_counter", 32'(counter), 32'd0);
    check("end_busy", 32'(busy), 32'd0);
    check("refill_cycles", 32'(cyc), 32'(10 + ((stall_word != 0) ? stall_n : 0)));
  endtask

  initial begin
    rst       = 1'b0;
    miss      = 1'b1;
    addr      = 32'h0000_0104;
    mem_ack   = 1'b0;
    mem_rdata = 32'd0;

    // Reset held for 3 cycles with miss asserted.
    for (int i = 0; i < 3; i++) begin
      tick();
      check_all_zero($sformatf("reset%0d", i));
    end
    rst = 1'b1;

    // Zero-wait refill, offset 0: selects 0,1,2,3, data 0xA0..0xA3.
    run_refill(32'h0000_0104, 32'h0000_00A0, 0, 0, 0);
    // Back-to-back critical-word-first wrap: offset 3 -> 3,0,1,2.
    run_refill(32'h0000_2003, 32'hBEEF_00B0, 0, 0, 0);
    // Memory stall: word 2 acked 3 cycles late.
    run_refill(32'h1234_5671, 32'hC0DE_00C0, 2, 3, 0);
    // Reset while counter==3, then the same miss restarts at offset.
    run_refill(32'h0000_4002, 32'h5555_00D0, 0, 0, 3);
    check("sb_empty_after_abort", 32'(sb.size()), 32'd0);
    run_refill(32'h0000_4002, 32'h6666_00E0, 0, 0, 0);

`ifdef REFILL_TIMEOUT_EN
    begin
      int  err_pulses;
      bit  saw5;
      bit  req_after_err;
      err_pulses    = 0;
      saw5          = 1'b0;
      req_after_err = 1'b0;
      miss = 1'b1;
      addr = 32'h0000_8001;
      for (int i = 0; i < 9; i++) begin
        tick();
        if (refill_err) err_pulses++;
        if (counter == 3'd5) saw5 = 1'b1;
        if (err_pulses > 0 && mem_req) req_after_err = 1'b1;
      end
      check("timeout_err_pulses", 32'(err_pulses), 32'd1);
      check("timeout_no_fill", 32'(saw5), 32'd0);
      check("timeout_retry_req", 32'(req_after_err), 32'd1);
      miss = 1'b0;
      rst  = 1'b0;
      tick();
      rst  = 1'b1;
    end
`endif

    check("final_busy", 32'(busy), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cache_refill_ctrl.md
# cache_refill_ctrl

Refill controller between the direct-mapped data cache and main memory. On a read miss it fetches the 4-word line from memory, critical word first, one word per memory handshake. It presents each word to the cache on `memory_word` with the cache's `counter` protocol: counter 1..4 carries the words, and counter 5 sets the valid bit and tag. The cache's `IsStall` output drives this block, and this block's `counter` and `memory_word` outputs drive the cache.

## Interface
- `TIMEOUT_CYCLES`, default 255: maximum number of cycles to wait for `mem_ack` per word. Used only with `REFILL_TIMEOUT_EN`.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous and active-low. The block is in reset while `rst`=0, sampled on `clk`.
- `miss` in 1: refill request. Connected to the cache `IsStall` (MemRead & !hit).
- `addr` in 32: CPU address. The same bus the cache sees. [1:0] is the word offset within the line.
- `mem_ack` in 1: memory accepts the request. `mem_rdata` is valid in the same cycle.
- `mem_rdata` in 32: memory read word.
- `mem_req` out 1: memory read request.
- `mem_addr` out 32: word address `{line_addr[31:2], wsel}`.
- `counter` out 3: refill phase to the cache. 0 = idle/no word; 1..4 = word k; 5 = finalize.
- `memory_word` out 32: word for the cache. Valid when `counter` is 1..4.
- `busy` out 1: refill in progress (state ≠ IDLE).
- `refill_err` out 1: one-cycle pulse on timeout. Constant 0 without the macro.

## Operation
- States: IDLE, REQ, DELIVER, FILL, and ERR (ERR only with the macro).
- IDLE → REQ when `miss`=1.
  - On that edge, latch `line_addr`=`addr[31:2]` and `off`=`addr[1:0]`.
  - Set word index k=1.
- REQ:
  - Hold `mem_req`=1 with `mem_addr`={line_addr, (off+k-1) mod 4}.
  - On `mem_ack`=1, capture `mem_rdata` into `memory_word` and go to DELIVER.
- DELIVER:
  - `counter`=k for exactly one cycle, with `mem_req`=0.
  - If k<4, then k←k+1 and go to REQ. If k=4, go to FILL.
- FILL: `counter`=5 for exactly one cycle, then go to IDLE.
- `counter` is 0 in every other state and cycle. Each value 1..5 appears exactly once per successful refill, in ascending order.
- Word order wraps modulo 4. Example: off=2 gives word selects 2,3,0,1.
- Latched address and offset are fixed for the whole refill. Changes on `addr` mid-refill are ignored.
- `miss` is sampled only in IDLE. A drop of `miss` mid-refill does not abort; the refill runs to completion.
- `memory_word` holds its last value outside DELIVER.
- Reset (`rst`=0) at any point:
  - Next state is IDLE.
  - `counter`=0, `mem_req`=0, `mem_addr`=0, `memory_word`=0, `busy`=0, `refill_err`=0.
  - Any in-flight memory request is dropped. Memory must tolerate this.

## Timing
- All outputs are registered. No combinational path from inputs to outputs.
- `mem_req` stays asserted until a cycle with `mem_ack`=1. It deasserts the following cycle.
- Cycle 0 is the IDLE cycle with `miss`=1. With zero-wait memory (ack the first cycle of each `mem_req`):
  - `mem_req` high in cycles 1,3,5,7.
  - `counter`=1,2,3,4 in cycles 2,4,6,8.
  - `counter`=5 in cycle 9.
  - IDLE in cycle 10.
  - Minimum refill is 10 cycles.
- Each memory wait cycle adds one cycle before the corresponding DELIVER.
- In cycle 10, `miss` is already 0 because the cache set valid at the cycle-9 edge, so no retrigger occurs. Back-to-back misses to another line start at cycle 10 at the earliest.

## Configuration
- Macro `REFILL_TIMEOUT_EN`.
- Defined:
  - An 8-bit (sized to `TIMEOUT_CYCLES`) wait counter runs in REQ and clears on entry to REQ.
  - If it reaches `TIMEOUT_CYCLES` without `mem_ack`, go to ERR.
  - ERR drives `refill_err`=1 and `counter`=0 for one cycle, then goes to IDLE.
  - FILL is skipped, so the cache line stays invalid. A still-asserted `miss` restarts the refill from k=1.
- Undefined: REQ waits indefinitely, ERR does not exist, and `refill_err` is tied to 0.

## Test plan
- Reset: hold `rst`=0 for 3 cycles with `miss`=1 → all outputs 0, `busy`=0; first `mem_req` occurs 1 cycle after `rst`=1.
- Zero-wait refill: addr=0x0000_0104, memory returns 0xA0..0xA3 per word → `mem_addr` word-select 0,1,2,3; `counter` 1,2,3,4,5 in cycles 2,4,6,8,9 with `memory_word`=0xA0..0xA3; total 10 cycles.
- Critical-word-first wrap: addr offset=3 → word-select order 3,0,1,2; `counter`=1 carries the word from select 3.
- Memory stalls: `mem_ack` delayed 3 cycles on word 2 → `mem_req` held 4 cycles; `counter`=2 appears 1 cycle after the ack; no duplicate counter values.
- Mid-refill reset: assert `rst`=0 while `counter`=3 → next cycle all outputs 0, IDLE; re-asserted `miss` restarts at word-select=off.
- `REFILL_TIMEOUT_EN`, `TIMEOUT_CYCLES`=4, `mem_ack` never high → `refill_err` pulses once, `counter` never reaches 5, and `mem_req` reasserts on retry.
